// File: rtl/fifo_bridge_pkg.sv
// Shared types and helpers for the sync_fifo read-side AXI4-Stream bridge.
// Field widths cover every legal RD_LATENCY (1..3) and PKT_LEN up to 65536.
package fifo_bridge_pkg;

  localparam int MAX_RD_LATENCY = 3;
  localparam int PTR_W  = 3;
  localparam int OCC_W  = 3;
  localparam int INF_W  = 2;
  localparam int BEAT_W = 16;

  typedef struct packed {
    logic [OCC_W-1:0]  occupancy;
    logic [INF_W-1:0]  in_flight;
    logic [BEAT_W-1:0] beat_cnt;
  } bridge_state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
    if (int'(ptr) == depth - 1) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_bridge_buf.sv
// Small register ring holding FIFO words until the stream side accepts them.
// The head entry is read combinationally so tdata is valid together with occupancy.
module fifo_rd_bridge_buf
  import fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [OCC_W-1:0]      o_occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_full    = (r_occ == OCC_W'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A full ring still accepts a word when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= AW'(ptr_inc(PTR_W'(r_wr_ptr), DEPTH));
      end
      if (w_do_pop) begin
        r_rd_ptr <= AW'(ptr_inc(PTR_W'(r_rd_ptr), DEPTH));
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_rd_axis_bridge.sv
// Drains sync_fifo into an AXI4-Stream master at one beat per clock, using read
// credits so every word requested from the FIFO always has a buffer slot waiting.
module fifo_rd_axis_bridge
  import fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int PKT_LEN    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_valid,
  input  logic                  i_empty,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic                  o_m_axis_tlast,
  output logic                  o_err
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int CW        = OCC_W + 1;

  logic [OCC_W-1:0]      w_occupancy;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [INF_W-1:0]      r_in_flight;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic                  r_err;
  bridge_state_t         w_state;
  logic [CW-1:0]         w_credit_used;
  logic                  w_tvalid;
  logic                  w_handshake;
  logic                  w_last_beat;
  logic                  w_err_orphan;
  logic                  w_err_ovf;
  logic                  w_push;
  logic                  w_rd_return;

  assign w_state = '{occupancy: w_occupancy, in_flight: r_in_flight, beat_cnt: r_beat_cnt};

  // Read issue depends only on registered state and i_empty, never on tready.
  assign w_credit_used = CW'(w_state.occupancy) + CW'(w_state.in_flight);
  assign o_rd_en       = !i_s_rst && !i_empty && (w_credit_used < CW'(BUF_DEPTH));

  assign w_tvalid     = !i_s_rst && (w_state.occupancy != '0);
  assign w_handshake  = w_tvalid && i_m_axis_tready;
  assign w_last_beat  = (w_state.beat_cnt == BEAT_W'(PKT_LEN - 1));

  assign w_err_orphan = i_rd_valid && (w_state.in_flight == '0);
  assign w_err_ovf    = i_rd_valid && (w_state.occupancy == OCC_W'(BUF_DEPTH)) && !w_handshake;
  assign w_push       = i_rd_valid && !w_err_orphan && !w_err_ovf;
  assign w_rd_return  = i_rd_valid && !w_err_orphan;

  fifo_rd_bridge_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .i_clk      (i_clk),
    .i_s_rst    (i_s_rst),
    .i_push     (w_push),
    .i_push_data(i_rd_data),
    .i_pop      (w_handshake),
    .o_data     (w_head_data),
    .o_occupancy(w_occupancy)
  );

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_in_flight <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      case ({o_rd_en, w_rd_return})
        2'b10:   r_in_flight <= r_in_flight + INF_W'(1);
        2'b01:   r_in_flight <= r_in_flight - INF_W'(1);
        default: ;
      endcase
      if (w_handshake) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BEAT_W'(1);
      end
      if (w_err_orphan || w_err_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_m_axis_tdata  = w_head_data;
  assign o_m_axis_tvalid = w_tvalid;
  assign o_m_axis_tlast  = w_last_beat && w_tvalid;
  assign o_err           = r_err;

endmodule
